// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the bit-serial add/sub
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    // Sequencer states; the encoding is fixed so debug tooling can decode it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Carry-in used for subtraction (two's complement: a + ~b + 1).
    localparam logic SUB_CIN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Command/result bundle between a command source (master) and
//               the bit-serial add/sub sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic             cin_init;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, cin_init, op_a, op_b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, sub, cin_init, op_a, op_b,
        output busy, done, result, carry_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell. Purely combinational; the clock
//               pin exists for pin compatibility with the library cell and is
//               not used inside.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  wire logic clock,
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      cout
);
    logic w_unused_clock;

    assign w_unused_clock = clock;
    assign sum            = a ^ b ^ cin;
    assign cout           = (a & b) | (a & cin) | (b & cin);
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Time-shares one full_adder cell to add or subtract two
//               WIDTH-bit operands bit-serially, LSB first, one bit per clock.
//               Reports the result with carry-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic        clock,
    input  wire logic        reset,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_carry_out;
    logic             r_overflow;

    logic             w_run;
    logic             w_fa_a;
    logic             w_fa_b;
    logic             w_fa_cin;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_msb;

    // Adder inputs come straight from registers, so they only move on edges;
    // outside RUN they are parked at zero.
    assign w_run    = (r_state == RUN);
    assign w_fa_a   = w_run & r_sh_a[0];
    assign w_fa_b   = w_run & r_sh_b[0];
    assign w_fa_cin = w_run & r_carry;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    full_adder U_full_adder (
        .clock (clock),
        .a     (w_fa_a),
        .b     (w_fa_b),
        .cin   (w_fa_cin),
        .sum   (w_fa_sum),
        .cout  (w_fa_cout)
    );

    // Current sum bit positioned at the MSB, ready to be ORed into the shifted result.
    always_comb begin
        w_sum_msb            = '0;
        w_sum_msb[WIDTH-1]   = w_fa_sum;
    end

    // Sequencer: load operands on start, shift one bit per cycle, report in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_sh_a  <= bus.op_a;
                        r_sh_b  <= bus.sub ? ~bus.op_b : bus.op_b;
                        r_carry <= bus.sub ? SUB_CIN : bus.cin_init;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_result <= (r_result >> 1) | w_sum_msb;
                    r_sh_a   <= r_sh_a >> 1;
                    r_sh_b   <= r_sh_b >> 1;
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Carry into the MSB is the stored carry; carry out is the cell's cout.
                        r_overflow  <= r_carry ^ w_fa_cout;
                        r_carry_out <= w_fa_cout;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=8 main
//               instance plus a WIDTH=1 boundary instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic clock;
    logic reset;

    serial_add_ctrl_if #(.WIDTH(8)) bus  ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request and push the reference result (sign-rule overflow).
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s, input logic cin);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] sum;
        bb    = s ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + {8'd0, (s ? 1'b1 : cin)};
        e.res = sum[7:0];
        e.co  = sum[8];
        e.ov  = (a[7] == bb[7]) && (sum[7] != a[7]);
        sb.push_back(e);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        bus.cin_init = cin;
        bus.start    = 1'b1;
    endtask

    // Wait (bounded) for done; optionally pulse a stray start during RUN.
    task automatic wait_done(input string tag, input bit inject);
        int   n;
        bit   busy_ok;
        exp_t e;
        n       = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (inject && n == 3) begin
                bus.op_a  = 8'hAA;
                bus.op_b  = 8'h55;
                bus.start = 1'b1;
            end
            if (inject && n == 4) bus.start = 1'b0;
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
        end while (bus.done !== 1'b1 && n < 40);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_latency"}, n, 32'd9);
        chk({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_sb_nonempty"}, {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, {24'd0, bus.result}, {24'd0, e.res});
            chk({tag, "_carry"}, {31'd0, bus.carry_out}, {31'd0, e.co});
            chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, e.ov});
        end
    endtask

    // done must be a single-cycle pulse and the sequencer must fall idle.
    task automatic one_shot(input string tag);
        @(negedge clock);
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int         dcount;
        logic [7:0] prev_res;
        logic [2:0] w1_tab [3];
        logic       bb1, c1;
        logic [1:0] s1;
        int         n1;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.sub       = 1'b0;
        bus.cin_init  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus1.start    = 1'b0;
        bus1.sub      = 1'b0;
        bus1.cin_init = 1'b0;
        bus1.op_a     = '0;
        bus1.op_b     = '0;

        repeat (3) @(negedge clock);
        chk("rst_busy",   {31'd0, bus.busy},      32'd0);
        chk("rst_done",   {31'd0, bus.done},      32'd0);
        chk("rst_result", {24'd0, bus.result},    32'd0);
        chk("rst_carry",  {31'd0, bus.carry_out}, 32'd0);
        chk("rst_ovf",    {31'd0, bus.overflow},  32'd0);
        reset = 1'b0;

        // 1. basic add with latency / busy window
        @(negedge clock); launch(8'h5A, 8'h33, 1'b0, 1'b0); wait_done("add5a33", 1'b0); one_shot("add5a33");
        // 2. carry-out and cin_init overflow
        @(negedge clock); launch(8'hFF, 8'h01, 1'b0, 1'b0); wait_done("addff01", 1'b0); one_shot("addff01");
        @(negedge clock); launch(8'h7F, 8'h00, 1'b0, 1'b1); wait_done("add7fcin", 1'b0); one_shot("add7fcin");
        // 3. subtraction (cin_init ignored)
        @(negedge clock); launch(8'h10, 8'h20, 1'b1, 1'b0); wait_done("sub1020", 1'b0); one_shot("sub1020");
        @(negedge clock); launch(8'h20, 8'h10, 1'b1, 1'b1); wait_done("sub2010", 1'b0); one_shot("sub2010");
        // 4. start during RUN is ignored
        @(negedge clock); launch(8'h01, 8'h01, 1'b0, 1'b0); wait_done("ignore", 1'b1); one_shot("ignore");
        dcount   = 0;
        prev_res = bus.result;
        repeat (12) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
        end
        chk("ignore_no_extra", dcount, 32'd0);
        chk("ignore_result_held", {24'd0, bus.result}, {24'd0, prev_res});

        // 5. asynchronous reset mid-RUN
        @(negedge clock); launch(8'h11, 8'h22, 1'b0, 1'b0);
        @(negedge clock); bus.start = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy",   {31'd0, bus.busy},      32'd0);
        chk("arst_done",   {31'd0, bus.done},      32'd0);
        chk("arst_result", {24'd0, bus.result},    32'd0);
        chk("arst_carry",  {31'd0, bus.carry_out}, 32'd0);
        chk("arst_ovf",    {31'd0, bus.overflow},  32'd0);
        sb.delete();
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        chk("arst_no_done", {31'd0, bus.done}, 32'd0);
        launch(8'h03, 8'h04, 1'b0, 1'b0); wait_done("post_rst", 1'b0); one_shot("post_rst");

        // 6. back-to-back: new start held during the DONE cycle
        @(negedge clock); launch(8'h12, 8'h34, 1'b0, 1'b0); wait_done("b2b_first", 1'b0);
        launch(8'h0F, 8'h01, 1'b0, 1'b0); wait_done("b2b_second", 1'b0); one_shot("b2b_second");

        // WIDTH=1 boundary: {a, b, sub}
        w1_tab[0] = 3'b110;
        w1_tab[1] = 3'b100;
        w1_tab[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus1.op_a     = w1_tab[i][2];
            bus1.op_b     = w1_tab[i][1];
            bus1.sub      = w1_tab[i][0];
            bus1.cin_init = 1'b0;
            bus1.start    = 1'b1;
            bb1 = w1_tab[i][0] ? ~w1_tab[i][1] : w1_tab[i][1];
            c1  = w1_tab[i][0];
            s1  = {1'b0, w1_tab[i][2]} + {1'b0, bb1} + {1'b0, c1};
            n1  = 0;
            do begin
                @(negedge clock);
                n1++;
                if (n1 == 1) bus1.start = 1'b0;
            end while (bus1.done !== 1'b1 && n1 < 20);
            chk($sformatf("w1_%0d_done", i),    {31'd0, bus1.done},      32'd1);
            chk($sformatf("w1_%0d_latency", i), n1,                      32'd2);
            chk($sformatf("w1_%0d_result", i),  {31'd0, bus1.result},    {31'd0, s1[0]});
            chk($sformatf("w1_%0d_carry", i),   {31'd0, bus1.carry_out}, {31'd0, s1[1]});
            chk($sformatf("w1_%0d_ovf", i),     {31'd0, bus1.overflow},  {31'd0, c1 ^ s1[1]});
        end

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that time-shares one full_adder cell to perform WIDTH-bit add/subtract bit-serially, LSB first, one bit per clock.
- Latches operands on a start pulse and feeds the full_adder one bit pair plus the stored carry each cycle.
- Collects sum bits into a result register and reports done, carry and signed overflow.
- Sits between a simple command source (testbench or small CPU datapath) and the existing full_adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled in IDLE or DONE only.
sub  input  1  1 = op_a - op_b, 0 = op_a + op_b + cin_init; sampled with start.
cin_init  input  1  carry-in for add; ignored when sub=1.
op_a  input  WIDTH  operand A, sampled with start.
op_b  input  WIDTH  operand B, sampled with start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when result is valid.
result  output  WIDTH  sum/difference; held until the next accepted start.
carry_out  output  1  final carry (add) / NOT borrow (sub); held with result.
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB; held with result.

Behaviour:
- Reset (async, any state): state=IDLE. busy=0, done=0, result=0, carry_out=0, overflow=0. Shift registers, carry register and counter = 0. An in-flight operation is discarded; no done is issued for it.
- full_adder instance: a, b, cin driven from the controller; sum and cout are used combinationally in the same cycle. Its clock port is tied to clock.
- FSM states: IDLE, RUN, DONE. Encoding is in the package.
- IDLE, start=1:
  - sh_a<=op_a; sh_b<=sub ? ~op_b : op_b.
  - carry<=sub ? 1 : cin_init; cnt<=0.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, every cycle:
  - FA inputs: a=sh_a[0], b=sh_b[0], cin=carry.
  - At the edge: result shifts right with fa.sum inserted at MSB; sh_a and sh_b shift right; carry<=fa.cout; cnt<=cnt+1.
  - When cnt==WIDTH-1: capture overflow<=carry^fa.cout and carry_out<=fa.cout, then go to DONE.
  - start is ignored throughout RUN.
- DONE (exactly one cycle): done=1, busy=0.
  - start=1: accept a new operation exactly as from IDLE and go to RUN, so back-to-back operations have no idle gap.
  - start=0: go to IDLE.
- Latency: with start sampled at edge E0, busy=1 for cycles E0..E0+WIDTH. done=1 in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after start is asserted.
- result, carry_out and overflow are only meaningful while done=1 and afterwards. They are overwritten bit by bit once the next operation starts.
- During RUN, the FA inputs change only on clock edges. In IDLE/DONE, the FA inputs are driven to 0.
- WIDTH=1 boundary: a single RUN cycle; overflow = carry-in XOR cout of that bit.
- No arithmetic widening: result is exactly WIDTH bits; the carry is reported only via carry_out.

Decomposition:
- Package serial_add_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and SUB_CIN constant = 1'b1.
- Sub-module: the existing full_adder cell, instantiated once as U_full_adder.
- Counter, shift registers and FSM stay in serial_add_ctrl; no further sub-modules.

Test Plan:
1. WIDTH=8, add, 0x5A+0x33, cin_init=0 -> result=0x8D, carry_out=0, overflow=1; done exactly 9 cycles after start asserted; busy high for the 8 preceding cycles.
2. Add 0xFF+0x01, cin_init=0 -> result=0x00, carry_out=1, overflow=0. Then 0x7F+0x00, cin_init=1 -> 0x80, carry_out=0, overflow=1.
3. sub=1, 0x10-0x20 (cin_init=0, ignored) -> result=0xF0, carry_out=0, overflow=0. Then 0x20-0x10 -> 0x10, carry_out=1.
4. Start 0x01+0x01, then pulse start with 0xAA/0x55 during RUN cycle 3 -> second request ignored; result=0x02, single done pulse.
5. Assert reset asynchronously mid-RUN (after 4 bits) -> busy/done/result/carry_out/overflow go to 0 without waiting for an edge. After release, 0x03+0x04 -> 0x07 with normal latency.
6. Hold start high with new operands (0x0F+0x01) during the DONE cycle -> first result valid in that cycle, busy rises on the next cycle, second done 9 cycles later with result=0x10.
